mem_arbiter: RTL

Two-port arbiter that shares one single-port synchronous memory between the ARM processor's data port and the VGA pixel fetch. It sits between the processor/VGA address sources and the RAM_Image/RAM_Histogram memories. It replaces the static enable-based address mux with per-cycle request/grant arbitration, bounded hold, and tagged read-data return. This lets the processor keep running while the display is active.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_rdpipe.sv | 32 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the processor/VGA memory arbiter.
package mem_arb_pkg;

  // Who currently owns the memory port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PROC = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  // Tag travelling alongside a read through the return pipe.
  typedef struct packed {
    logic   valid;
    owner_t id;
  } rtag_t;

  // Legal range for the memory read latency.
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  function automatic logic rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_rdpipe.sv
// Read-return tag pipe: delays each accepted-read tag by DEPTH edges so it
// lines up with the memory's read data.
module mem_arb_rdpipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk,
  input  logic  clr_n,
  input  rtag_t tag_i,
  output rtag_t tag_o
);

  rtag_t stage_q [DEPTH];

  // Shift tags forward every cycle; a low clr_n flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Per-cycle request/grant arbiter sharing one single-port memory between the
// processor data port and the VGA pixel fetch, with bounded hold and tagged
// read-data return.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_HOLD     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  generate
    if (!rd_lat_ok(READ_LATENCY) || (MAX_HOLD < 1)) begin : g_param_check
      $error("mem_arbiter: READ_LATENCY must be 1..4 and MAX_HOLD >= 1");
    end
  endgenerate

  owner_t            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_p, grant_v;
  rtag_t             push_tag, ret_tag;

  // Grant decision: single requester always wins; contention goes to VGA from
  // idle, then stays with the owner until its hold budget runs out.
  always_comb begin
    grant_p = 1'b0;
    grant_v = 1'b0;
    if (reset) begin
      if (p_req && v_req) begin
        if (owner_q == OWN_NONE) begin
          grant_v = 1'b1;
        end else if (hold_q < HOLD_MAX) begin
          grant_p = (owner_q == OWN_PROC);
          grant_v = (owner_q == OWN_VGA);
        end else begin
          grant_p = (owner_q == OWN_VGA);
          grant_v = (owner_q == OWN_PROC);
        end
      end else begin
        grant_p = p_req;
        grant_v = v_req;
      end
    end
  end

  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;

  // Next owner and hold count follow whoever was granted this cycle.
  always_comb begin
    owner_d = OWN_NONE;
    hold_d  = '0;
    if (grant_p) begin
      owner_d = OWN_PROC;
      hold_d  = (owner_q == OWN_PROC) ? hold_inc : HOLD_ONE;
    end else if (grant_v) begin
      owner_d = OWN_VGA;
      hold_d  = (owner_q == OWN_VGA) ? hold_inc : HOLD_ONE;
    end
  end

  // Memory command mux; with no grant the bus keeps the last granted values.
  always_comb begin
    m_addr  = addr_q;
    m_wdata = wdata_q;
    m_we    = 1'b0;
    if (!reset) begin
      m_addr  = '0;
      m_wdata = '0;
    end else if (grant_p) begin
      m_addr  = p_addr;
      m_wdata = p_wdata;
      m_we    = p_we;
    end else if (grant_v) begin
      m_addr  = v_addr;
    end
  end

  // Arbitration state and held bus values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      hold_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
      addr_q  <= m_addr;
      wdata_q <= m_wdata;
    end
  end

  // Tag each accepted read with its requester; writes and idle push nothing.
  always_comb begin
    push_tag.valid = (grant_p && !p_we) || grant_v;
    push_tag.id    = grant_p ? OWN_PROC : (grant_v ? OWN_VGA : OWN_NONE);
  end

  mem_arb_rdpipe #(
    .DEPTH (READ_LATENCY)
  ) u_rdpipe (
    .clk   (clk),
    .clr_n (reset),
    .tag_i (push_tag),
    .tag_o (ret_tag)
  );

  // Returned data is broadcast; the valid strobes steer it to its owner.
  assign p_gnt    = grant_p;
  assign v_gnt    = grant_v;
  assign p_rvalid = reset && ret_tag.valid && (ret_tag.id == OWN_PROC);
  assign v_rvalid = reset && ret_tag.valid && (ret_tag.id == OWN_VGA);
  assign p_rdata  = m_rdata;
  assign v_rdata  = m_rdata;

endmodule
